// File: rtl/bitstream_rng_array_if.sv
// rtl/bitstream_rng_array_if.sv - shadow-register load bus for bitstream_rng_array
interface bitstream_rng_array_if #(
  parameter int BITWIDTH = 20,
  parameter int NUM_CH   = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                load_valid;
  logic                load_ready;
  logic [CH_W-1:0]     load_ch;
  logic [BITWIDTH-1:0] load_value;
  logic                load_neg;

  modport master (
    output load_valid, load_ch, load_value, load_neg,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_ch, load_value, load_neg,
    output load_ready
  );
endinterface

// File: rtl/bitstream_rng_array.sv
// rtl/bitstream_rng_array.sv - multi-channel LFSR stochastic bitstream source with shadow/active values
// Optional per-channel saturating ones counters via `BITSTREAM_ONES_COUNT_EN.
module bitstream_rng_array #(
  parameter int          BITWIDTH = 20,
  parameter int          NUM_CH   = 4,
  parameter logic [63:0] SEED     = 64'h5A5A5,
  parameter int          CNT_W    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic                     apply,
  bitstream_rng_array_if.slave     load,
  output logic [NUM_CH-1:0]        out_p,
  output logic [NUM_CH-1:0]        out_m
`ifdef BITSTREAM_ONES_COUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]  ones_cnt
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Maximal-length tap sets; tap n sits at bit n-1 and feeds the LSB of a left shift.
  localparam logic [63:0] TAP_MASK =
    (BITWIDTH == 16) ? 64'h0000_0000_0000_D008 :
    (BITWIDTH == 20) ? 64'h0000_0000_0009_0000 :
    (BITWIDTH == 32) ? 64'h0000_0000_8020_0003 :
                       64'hD800_0000_0000_0000;
  localparam logic [BITWIDTH-1:0] TAPS = TAP_MASK[BITWIDTH-1:0];

  if (!(BITWIDTH == 16 || BITWIDTH == 20 || BITWIDTH == 32 || BITWIDTH == 64)) begin : g_bad_bitwidth
    $error("bitstream_rng_array: BITWIDTH must be 16, 20, 32 or 64");
  end
  if (NUM_CH < 1 || NUM_CH > 64) begin : g_bad_num_ch
    $error("bitstream_rng_array: NUM_CH must be in 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("bitstream_rng_array: CNT_W must be at least 1");
  end

  function automatic logic [BITWIDTH-1:0] chan_seed(input int c);
    logic [63:0] s;
    s = SEED + 64'(c) * 64'h9E37;
    if (s[BITWIDTH-1:0] == '0)
      chan_seed = {{(BITWIDTH-1){1'b0}}, 1'b1};
    else
      chan_seed = s[BITWIDTH-1:0];
  endfunction

  logic ready_q;
  logic accept;

  always_ff @(posedge CLK) begin
    if (RST) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign load.load_ready = ready_q;
  assign accept          = load.load_valid & ready_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [CH_W-1:0]     IDX    = CH_W'(c);
    localparam logic [BITWIDTH-1:0] SEED_C = chan_seed(c);

    logic [BITWIDTH-1:0] lfsr_q;
    logic [BITWIDTH-1:0] shadow_val_q;
    logic [BITWIDTH-1:0] active_val_q;
    logic                shadow_neg_q;
    logic                active_neg_q;
    logic                p_q;
    logic                m_q;
    logic                hit;
    logic                wr;

    assign hit = lfsr_q < active_val_q;
    // Out-of-range channel numbers never match any IDX, so such writes are dropped.
    assign wr  = accept && (load.load_ch == IDX);

    always_ff @(posedge CLK) begin
      if (RST) begin
        lfsr_q       <= SEED_C;
        shadow_val_q <= '0;
        shadow_neg_q <= 1'b0;
        active_val_q <= '0;
        active_neg_q <= 1'b0;
        p_q          <= 1'b0;
        m_q          <= 1'b0;
      end else begin
        if (en) begin
          lfsr_q <= {lfsr_q[BITWIDTH-2:0], ^(lfsr_q & TAPS)};
          p_q    <= hit & ~active_neg_q;
          m_q    <= hit &  active_neg_q;
        end
        // Apply copies the shadow as it was before any same-edge write.
        if (apply) begin
          active_val_q <= shadow_val_q;
          active_neg_q <= shadow_neg_q;
        end
        if (wr) begin
          shadow_val_q <= load.load_value;
          shadow_neg_q <= load.load_neg;
        end
      end
    end

    assign out_p[c] = p_q;
    assign out_m[c] = m_q;

`ifdef BITSTREAM_ONES_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
      if (RST || apply)
        cnt_q <= '0;
      else if (en && (p_q || m_q) && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end

    assign ones_cnt[c*CNT_W +: CNT_W] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_bitstream_rng_array.sv
// tb/tb_bitstream_rng_array.sv - bench for bitstream_rng_array: reference model, vector table, directed corners
module tb_bitstream_rng_array;
  localparam int          BW   = 20;
  localparam int          NCH  = 5;
  localparam int          CW   = 4;
  localparam int          CHW  = 3;
  localparam logic [63:0] SEED = 64'h5A5A5;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             en;
  logic             apply;
  logic [NCH-1:0]   out_p;
  logic [NCH-1:0]   out_m;
`ifdef BITSTREAM_ONES_COUNT_EN
  logic [NCH*CW-1:0] ones_cnt;
`endif

  bitstream_rng_array_if #(.BITWIDTH(BW), .NUM_CH(NCH)) bus ();

  bitstream_rng_array #(
    .BITWIDTH (BW),
    .NUM_CH   (NCH),
    .SEED     (SEED),
    .CNT_W    (CW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .apply    (apply),
    .load     (bus),
    .out_p    (out_p),
    .out_m    (out_m)
`ifdef BITSTREAM_ONES_COUNT_EN
    ,
    .ones_cnt (ones_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference state: channel values, LFSR sequence position and expected rail bits.
  logic [BW-1:0] m_lfsr    [NCH];
  logic [BW-1:0] m_sh_val  [NCH];
  logic [BW-1:0] m_act_val [NCH];
  bit            m_sh_neg  [NCH];
  bit            m_act_neg [NCH];
  bit            m_p       [NCH];
  bit            m_m       [NCH];
  int            m_cnt     [NCH];
  bit            m_ready;
  int            ones_p    [NCH];
  int            ones_m    [NCH];

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          ch;
    logic [BW-1:0] val;
    bit          neg;
    int          run;
    int          p_lo;
    int          p_hi;
    int          m_lo;
    int          m_hi;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [BW-1:0] seed_of(input int c);
    longint unsigned s;
    s = (SEED + longint'(c) * 64'h9E37) % (64'd1 << BW);
    if (s == 0) s = 1;
    return s[BW-1:0];
  endfunction

  // x^20 + x^17 + 1, new bit enters at the bottom.
  function automatic logic [BW-1:0] lfsr_next(input logic [BW-1:0] s);
    int taps[2] = '{20, 17};
    bit fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return {s[BW-2:0], fb};
  endfunction

  task automatic check(input string name, input int ch, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic clear_tally();
    for (int c = 0; c < NCH; c++) begin
      ones_p[c] = 0;
      ones_m[c] = 0;
    end
  endtask

  task automatic step();
    bit acc;
    bit hit;
    @(posedge CLK);
    if (RST) begin
      for (int c = 0; c < NCH; c++) begin
        m_lfsr[c]    = seed_of(c);
        m_sh_val[c]  = '0;
        m_sh_neg[c]  = 1'b0;
        m_act_val[c] = '0;
        m_act_neg[c] = 1'b0;
        m_p[c]       = 1'b0;
        m_m[c]       = 1'b0;
        m_cnt[c]     = 0;
      end
      m_ready = 1'b0;
    end else begin
      acc = bus.load_valid && m_ready;
      if (en) begin
        for (int c = 0; c < NCH; c++) begin
          if ((m_p[c] || m_m[c]) && m_cnt[c] < CNT_MAX) m_cnt[c]++;
          hit       = m_lfsr[c] < m_act_val[c];
          m_p[c]    = hit && !m_act_neg[c];
          m_m[c]    = hit &&  m_act_neg[c];
          m_lfsr[c] = lfsr_next(m_lfsr[c]);
        end
      end
      if (apply) begin
        for (int c = 0; c < NCH; c++) begin
          m_act_val[c] = m_sh_val[c];
          m_act_neg[c] = m_sh_neg[c];
          m_cnt[c]     = 0;
        end
      end
      if (acc && int'(bus.load_ch) < NCH) begin
        m_sh_val[bus.load_ch] = bus.load_value;
        m_sh_neg[bus.load_ch] = bus.load_neg;
      end
      m_ready = 1'b1;
    end
    #1;
    check("load_ready", -1, bus.load_ready, m_ready);
    for (int c = 0; c < NCH; c++) begin
      check("out_p", c, out_p[c], m_p[c]);
      check("out_m", c, out_m[c], m_m[c]);
      check("rails_exclusive", c, out_p[c] & out_m[c], 0);
`ifdef BITSTREAM_ONES_COUNT_EN
      check("ones_cnt", c, ones_cnt[c*CW +: CW], m_cnt[c]);
`endif
      ones_p[c] += int'(out_p[c]);
      ones_m[c] += int'(out_m[c]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input int ch, input logic [BW-1:0] val, input bit neg, input bit ap);
    bus.load_valid = 1'b1;
    bus.load_ch    = CHW'(ch);
    bus.load_value = val;
    bus.load_neg   = neg;
    apply          = ap;
    step();
    bus.load_valid = 1'b0;
    apply          = 1'b0;
  endtask

  task automatic pulse_apply();
    apply = 1'b1;
    step();
    apply = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0] snap_p;
    logic [NCH-1:0] snap_m;
    int r;

    vecs[0] = '{0, 20'h00000, 1'b0, 2000,    0,    0,   0,   0};
    vecs[1] = '{2, 20'hFFFFF, 1'b0, 2000, 1999, 2000,   0,   0};
    vecs[2] = '{4, 20'h20000, 1'b1, 2000,    0,    0, 190, 310};
    vecs[3] = '{1, 20'hC0000, 1'b0, 2000, 1420, 1580,   0,   0};
    vecs[4] = '{3, 20'h00001, 1'b0, 2000,    0,    0,   0,   0};

    RST            = 1'b1;
    en             = 1'b0;
    apply          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_ch    = '0;
    bus.load_value = '0;
    bus.load_neg   = 1'b0;
    m_ready        = 1'b0;
    clear_tally();

    // Reset held two cycles, then release.
    run(2);
    check("t1_ready_in_reset", -1, bus.load_ready, 0);
    RST = 1'b0;
    en  = 1'b1;
    step();
    check("t1_ready_after_release", -1, bus.load_ready, 1);

    // Shadow write without apply must stay invisible.
    do_load(1, 20'h80000, 1'b0, 1'b0);
    clear_tally();
    run(100);
    check("t2_no_apply_silent", 1, ones_p[1] + ones_m[1], 0);
    pulse_apply();
    clear_tally();
    run(8192);
    check_range("t2_half_density", ones_p[1], 4096 - 164, 4096 + 164);
    check("t2_out_m_silent", 1, ones_m[1], 0);

    // Vector table: load, apply, measure rail densities.
    foreach (vecs[i]) begin
      do_load(vecs[i].ch, vecs[i].val, vecs[i].neg, 1'b0);
      pulse_apply();
      clear_tally();
      run(vecs[i].run);
      check_range($sformatf("vec%0d_p_ones", i), ones_p[vecs[i].ch], vecs[i].p_lo, vecs[i].p_hi);
      check_range($sformatf("vec%0d_m_ones", i), ones_m[vecs[i].ch], vecs[i].m_lo, vecs[i].m_hi);
    end

    // Load and apply on the same edge: apply sees the old shadow.
    do_load(3, 20'h40000, 1'b1, 1'b1);
    clear_tally();
    run(200);
    check("t4_same_cycle_unchanged", 3, ones_p[3] + ones_m[3], 0);
    pulse_apply();
    clear_tally();
    run(4000);
    check_range("t4_quarter_density", ones_m[3], 1000 - 90, 1000 + 90);
    check("t4_out_p_silent", 3, ones_p[3], 0);

    // Freeze for 10 cycles, with an out-of-range load and an apply inside the window.
    for (int c = 0; c < NCH; c++) begin
      snap_p[c] = m_p[c];
      snap_m[c] = m_m[c];
    end
    en = 1'b0;
    do_load(5, 20'hFFFFF, 1'b0, 1'b0);
    do_load(7, 20'h12345, 1'b1, 1'b0);
    pulse_apply();
    run(7);
    check("t5_frozen_p", -1, out_p, snap_p);
    check("t5_frozen_m", -1, out_m, snap_m);
    en = 1'b1;
    run(200);

    // Reset mid-operation discards the pending shadow write.
    do_load(0, 20'hFFFFF, 1'b0, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    pulse_apply();
    clear_tally();
    run(100);
    r = 0;
    for (int c = 0; c < NCH; c++) r += ones_p[c] + ones_m[c];
    check("reset_discards_shadow", -1, r, 0);

`ifdef BITSTREAM_ONES_COUNT_EN
    do_load(0, 20'hFFFFF, 1'b0, 1'b0);
    pulse_apply();
    run(40);
    check("t6_cnt_saturated", 0, ones_cnt[0 +: CW], CNT_MAX);
    pulse_apply();
    check("t6_cnt_cleared", 0, ones_cnt[0 +: CW], 0);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      RST            = ($urandom_range(0, 199) == 0);
      en             = ($urandom_range(0, 9) != 0);
      bus.load_valid = ($urandom_range(0, 2) == 0);
      bus.load_ch    = CHW'($urandom_range(0, 7));
      r              = int'($urandom_range(0, 3));
      bus.load_value = (r == 0) ? '0 : (r == 1) ? '1 : BW'($urandom);
      bus.load_neg   = 1'($urandom_range(0, 1));
      apply          = ($urandom_range(0, 19) == 0);
      step();
    end
    RST            = 1'b0;
    en             = 1'b1;
    bus.load_valid = 1'b0;
    apply          = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
